// File: rtl/xalu_acc.sv
// Nibble-serial ALU with accumulator: one 4-bit slice of acc is rewritten per cycle.
// Optional subtract support is compiled in with `define XALU_SUB_EN.
module xalu_acc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         start,
  input  logic [2:0]   func,
  input  logic [W-1:0] op_b,
  input  logic         com,
  input  logic         ci_right,
  input  logic         ci_left,
  input  logic         sub,
  output logic [W-1:0] acc,
  output logic         busy,
  output logic         done,
  output logic         co_left,
  output logic         co_right,
  output logic         zero,
  output logic         neg_zero,
  output logic         equ
);

  localparam int N  = W / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef enum logic [2:0] {
    F_ADD   = 3'd0,
    F_AND   = 3'd1,
    F_OR    = 3'd2,
    F_XOR   = 3'd3,
    F_PASSA = 3'd4,
    F_PASSB = 3'd5,
    F_SHR   = 3'd6,
    F_SHL   = 3'd7
  } func_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          c_q, c_d;
  logic [W-1:0]  acc_q, acc_d;
  func_t         func_q, func_d;
  logic [W-1:0]  b_q, b_d;
  logic          com_q, com_d;
  logic          cil_q, cil_d;
  logic          cir_q, cir_d;
  logic          done_q, done_d;
  logic          co_left_q, co_left_d;
  logic          co_right_q, co_right_d;
  logic          equ_q, equ_d;

`ifdef XALU_SUB_EN
  logic          sub_q, sub_d;
`else
  logic          sub_unused;
  assign sub_unused = sub;
`endif

  logic [3:0]    a_s, b_s, b_e, res, res_w;
  logic          hi_bit, c_next, last_slice;
  logic [4:0]    sum;
  logic [W:0]    ext;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    c_d        = c_q;
    acc_d      = acc_q;
    func_d     = func_q;
    b_d        = b_q;
    com_d      = com_q;
    cil_d      = cil_q;
    cir_d      = cir_q;
    done_d     = done_q;
    co_left_d  = co_left_q;
    co_right_d = co_right_q;
    equ_d      = equ_q;
`ifdef XALU_SUB_EN
    sub_d      = sub_q;
`endif

    // Current slice of A and B; hi_bit is the bit just above the slice, which
    // is still original A (or the left fill bit above the top slice).
    ext    = {cil_q, acc_q};
    a_s    = '0;
    b_s    = '0;
    hi_bit = cil_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        a_s    = acc_q[4*i +: 4];
        b_s    = b_q[4*i +: 4];
        hi_bit = ext[4*i+4];
      end
    end
    last_slice = (k_q == KW'(N-1));

`ifdef XALU_SUB_EN
    b_e = sub_q ? ~b_s : b_s;
`else
    b_e = b_s;
`endif

    sum    = '0;
    res    = '0;
    c_next = c_q;
    case (func_q)
      F_ADD: begin
        sum    = {1'b0, a_s} + {1'b0, b_e} + {4'b0000, c_q};
        res    = sum[3:0];
        c_next = sum[4];
      end
      F_AND:   res = a_s & b_s;
      F_OR:    res = a_s | b_s;
      F_XOR:   res = a_s ^ b_s;
      F_PASSA: res = a_s;
      F_PASSB: res = b_s;
      F_SHR: begin
        res = {hi_bit, a_s[3:1]};
        if (k_q == '0) c_next = a_s[0];
      end
      // c carries the overwritten top bit of the previous slice into this one
      F_SHL: begin
        res    = {a_s[2:0], c_q};
        c_next = a_s[3];
      end
      default: res = a_s;
    endcase
    res_w = res ^ {4{com_q}};

    if (ena) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            func_d  = func_t'(func);
            b_d     = op_b;
            com_d   = com;
            cil_d   = ci_left;
            cir_d   = ci_right;
            c_d     = ci_right;
`ifdef XALU_SUB_EN
            sub_d   = sub && (func_t'(func) == F_ADD);
            if (sub_d) c_d = 1'b1;
`endif
            equ_d   = (acc_q == op_b);
            k_d     = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < N; i++) begin
            if (k_q == KW'(i)) acc_d[4*i +: 4] = res_w;
          end
          c_d = c_next;
          k_d = k_q + KW'(1);
          if (last_slice) begin
            k_d        = '0;
            state_d    = IDLE;
            done_d     = 1'b1;
            co_left_d  = ((func_q == F_ADD) || (func_q == F_SHL)) ? c_next : 1'b0;
            co_right_d = (func_q == F_SHR) ? c_next : 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      c_q        <= 1'b0;
      acc_q      <= '0;
      func_q     <= F_ADD;
      b_q        <= '0;
      com_q      <= 1'b0;
      cil_q      <= 1'b0;
      cir_q      <= 1'b0;
      done_q     <= 1'b0;
      co_left_q  <= 1'b0;
      co_right_q <= 1'b0;
      equ_q      <= 1'b0;
`ifdef XALU_SUB_EN
      sub_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      c_q        <= c_d;
      acc_q      <= acc_d;
      func_q     <= func_d;
      b_q        <= b_d;
      com_q      <= com_d;
      cil_q      <= cil_d;
      cir_q      <= cir_d;
      done_q     <= done_d;
      co_left_q  <= co_left_d;
      co_right_q <= co_right_d;
      equ_q      <= equ_d;
`ifdef XALU_SUB_EN
      sub_q      <= sub_d;
`endif
    end
  end

  assign acc      = acc_q;
  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign co_left  = co_left_q;
  assign co_right = co_right_q;
  assign equ      = equ_q;
  assign zero     = (acc_q == '0);
  assign neg_zero = (acc_q == '1);

endmodule

// File: tb/tb_xalu_acc.sv
// Directed bench for xalu_acc (W=8): chained vector table plus control-corner sequences.
module tb_xalu_acc;

  localparam logic [2:0] F_ADD = 3'd0, F_AND = 3'd1, F_OR = 3'd2, F_XOR = 3'd3,
                         F_PASSA = 3'd4, F_PASSB = 3'd5, F_SHR = 3'd6, F_SHL = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n, ena, start, com, ci_right, ci_left, sub;
  logic [2:0] func;
  logic [7:0] op_b, acc;
  logic       busy, done, co_left, co_right, zero, neg_zero, equ;

  int checks = 0;
  int errors = 0;

  xalu_acc #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .func(func),
    .op_b(op_b), .com(com), .ci_right(ci_right), .ci_left(ci_left), .sub(sub),
    .acc(acc), .busy(busy), .done(done), .co_left(co_left), .co_right(co_right),
    .zero(zero), .neg_zero(neg_zero), .equ(equ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] func;
    logic [7:0] b;
    logic       com, cir, cil, sb;
    logic [7:0] acc;
    logic       col, cor, zero, negz, equ;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic launch(input logic [2:0] f, input logic [7:0] b, input logic cm,
                        input logic cr, input logic cl, input logic sb);
    func = f; op_b = b; com = cm; ci_right = cr; ci_left = cl; sub = sb; start = 1'b1;
  endtask

  // Waits (bounded) for done; returns number of edges seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    @(negedge clk);
    launch(v.func, v.b, v.com, v.cir, v.cil, v.sb);
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
    wait_done(lat);
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'd2);
    chk($sformatf("v%0d_acc", idx), 32'(acc), 32'(v.acc));
    chk($sformatf("v%0d_co_left", idx), 32'(co_left), 32'(v.col));
    chk($sformatf("v%0d_co_right", idx), 32'(co_right), 32'(v.cor));
    chk($sformatf("v%0d_zero", idx), 32'(zero), 32'(v.zero));
    chk($sformatf("v%0d_neg_zero", idx), 32'(neg_zero), 32'(v.negz));
    chk($sformatf("v%0d_equ", idx), 32'(equ), 32'(v.equ));
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", idx), 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int done_seen;

    //         func     b      com   cir   cil   sub   acc    col   cor   zero  negz  equ
    vt[0]  = '{F_PASSB, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{F_ADD,   8'h5B, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{F_PASSB, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{F_SHL,   8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{F_PASSB, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{F_SHR,   8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{F_PASSB, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{F_AND,   8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{F_XOR,   8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[9]  = '{F_PASSB, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef XALU_SUB_EN
    vt[10] = '{F_ADD,   8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    vt[10] = '{F_ADD,   8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    vt[11] = '{F_PASSB, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[12] = '{F_OR,    8'hC4, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[13] = '{F_ADD,   8'h0A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[14] = '{F_SHR,   8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[15] = '{F_SHL,   8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[16] = '{F_PASSA, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[17] = '{F_ADD,   8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; func = '0; op_b = '0;
    com = 1'b0; ci_right = 1'b0; ci_left = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_acc", 32'(acc), 32'h00);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_neg_zero", 32'(neg_zero), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_co", 32'({co_left, co_right, equ}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) run_vec(i, vt[i]);

    // start held into the first busy cycle must be ignored
    @(negedge clk);
    launch(F_PASSB, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    op_b = 8'h22;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("busy_start_lat", 32'(lat), 32'd1);
    chk("busy_start_acc", 32'(acc), 32'h11);
    repeat (3) @(negedge clk);
    chk("busy_start_idle", 32'(busy), 32'd0);
    chk("busy_start_acc2", 32'(acc), 32'h11);

    // start in the done cycle is accepted
    launch(F_PASSB, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("donecyc_acc1", 32'(acc), 32'h44);
    launch(F_PASSB, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk("donecyc_busy", 32'(busy), 32'd1);
    chk("donecyc_done", 32'(done), 32'd0);
    wait_done(lat);
    chk("donecyc_lat", 32'(lat), 32'd2);
    chk("donecyc_acc2", 32'(acc), 32'h55);

    // ena low freezes the operation, and done holds while frozen
    @(negedge clk);
    launch(F_PASSB, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    ena = 1'b0;
    repeat (3) @(negedge clk);
    chk("ena_busy", 32'(busy), 32'd1);
    chk("ena_acc", 32'(acc), 32'h55);
    ena = 1'b1;
    wait_done(lat);
    chk("ena_lat", 32'(lat), 32'd2);
    chk("ena_acc2", 32'(acc), 32'h3C);
    ena = 1'b0;
    @(negedge clk);
    chk("ena_done_hold", 32'(done), 32'd1);
    ena = 1'b1;
    @(negedge clk);
    chk("ena_done_clr", 32'(done), 32'd0);

    // reset mid-RUN aborts with no done; reset overrides start
    launch(F_PASSB, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_slice0", 32'(acc), 32'h36);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("mid_rst_acc", 32'(acc), 32'h00);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_zero", 32'(zero), 32'd1);
    rst_n = 1'b1;
    start = 1'b0;
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("mid_rst_no_done", 32'(done_seen), 32'd0);
    chk("mid_rst_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xalu_acc.md
XALU_ACC -- requirements
Module: xalu_acc

Interface
REQ-001 SHALL have parameter W, default 8, datapath width in bits; legal values are multiples of 4 with W >= 4.
REQ-002 SHALL derive N = W/4, the number of 4-bit slices processed, one slice per cycle.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 ena  input  1  design enable; when low, all registers hold.
REQ-006 start  input  1  request one operation; sampled only in IDLE.
REQ-007 func  input  3  operation code: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL.
REQ-008 op_b  input  W  operand B; the accumulator acts as operand A.
REQ-009 com  input  1  ones-complement the result before writeback.
REQ-010 ci_right  input  1  right carry input: ADD carry-in and SHL fill bit.
REQ-011 ci_left  input  1  left carry input: SHR fill bit.
REQ-012 sub  input  1  subtract modifier for ADD; effective only when XALU_SUB_EN is defined.
REQ-013 acc  output  W  accumulator register.
REQ-014 busy  output  1  high while an operation is in progress.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 co_left, co_right  output  1 each  registered left and right carry outputs.
REQ-017 zero, neg_zero, equ  output  1 each  status: acc all zeros, acc all ones, A equals B at start.

Function
REQ-018 SHALL implement a two-state FSM with states IDLE and RUN, plus slice index k (0..N-1) and carry register c.
REQ-019 In IDLE with ena=1 and start=1, the block SHALL capture func, op_b, com, ci_left, ci_right and sub, and SHALL load c from ci_right (or 1 when subtracting).
REQ-020 On that same edge the block SHALL register equ = (acc == op_b), clear k, and enter RUN.
REQ-021 While in RUN, each edge SHALL write slice k (bits 4k+3..4k) as com XOR slice_result, then increment k.
REQ-022 The block SHALL return to IDLE on the edge that writes slice N-1.
REQ-023 Latency: busy SHALL be high for exactly N cycles after the start edge, and done SHALL be high on the cycle immediately after the final write.
REQ-024 ADD SHALL ripple carry through the 4 slice bits, latch the slice carry-out into c, and set co_left to the final carry-out.
REQ-025 AND, OR, XOR, PASSA and PASSB SHALL be bitwise on A and the captured B.
REQ-026 SHL: result bit i = A[i-1], bit 0 = captured ci_right; co_left = original A[W-1].
REQ-027 SHR: result bit i = A[i+1], bit W-1 = captured ci_left; co_right = original A[0]. Because higher slices are still unwritten, they supply the original A bits.
REQ-028 co_left and co_right SHALL update only when done pulses, and SHALL be 0 for any func that does not drive them.
REQ-029 zero and neg_zero SHALL be combinational on acc.
REQ-030 A start while busy SHALL be ignored, with no queuing.
REQ-031 A start asserted in the done cycle SHALL be accepted, because the FSM is already in IDLE.
REQ-032 When ena=0, the FSM, acc, c, k and the flags SHALL hold, and done SHALL hold its value.

Reset
REQ-033 While rst_n=0 at a clock edge, the block SHALL set acc=0, state=IDLE, k=0, c=0, busy=0, done=0, co_left=0, co_right=0 and equ=0, which gives zero=1 and neg_zero=0.
REQ-034 A reset during RUN SHALL abort the operation with no done pulse; reset SHALL override both ena and start.

Configuration
REQ-035 When XALU_SUB_EN is defined, ADD with captured sub=1 SHALL use ~B and carry-in 1, so acc = A - B.
REQ-036 When subtracting, co_left SHALL be 1 when no borrow occurs.
REQ-037 When XALU_SUB_EN is not defined, sub SHALL be ignored, ADD SHALL always be A + B + ci_right, and the subtract logic SHALL be absent.

Verification (W=8)
REQ-038 Reset: hold rst_n low 2 cycles -> acc=0x00, zero=1, busy=0, done=0.
REQ-039 PASSB 0xA5, then ADD 0x5B with ci_right=0 -> acc=0x00, co_left=1, zero=1; done pulses exactly 2 cycles after each start edge.
REQ-040 Shifts: acc=0x81, SHL with ci_right=1 -> acc=0x03, co_left=1; acc=0x81, SHR with ci_left=0 -> acc=0x40, co_right=1.
REQ-041 Complement and equ: acc=0x0F, AND 0xF0 with com=1 -> acc=0xFF, neg_zero=1, equ=0; then XOR 0xFF -> equ=1, acc=0x00.
REQ-042 Control: start at the busy+1 cycle is ignored; start in the done cycle is accepted; rst_n=0 mid-RUN -> acc=0, no done pulse.
REQ-043 Subtract: acc=0x10, ADD 0x01 with sub=1 -> with XALU_SUB_EN, acc=0x0F and co_left=1; without XALU_SUB_EN, acc=0x11.
